motor_pwm_multi: RTL and testbench

MOTOR_PWM_MULTI -- requirements
Module: motor_pwm_multi

---
 rtl/motor_pwm_multi.sv | 174 +++++++++++++++++
 tb/tb_motor_pwm_multi.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : motor_pwm_multi
//  Description : Multi-channel motor PWM driver with duty ramping, controlled
//                deceleration and dead time on direction reversal. All
//                channels share one free-running period counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CH         number of motor channels (1..8)
//    CW         counter / duty width in bits (4..16)
//    RAMP_STEP  largest duty change applied per PWM period (1..2^CW-1)
//    DEAD_PER   PWM periods held low while the direction flips (1..255)
//  Ports
//    clk          system clock, rising edge
//    rst          synchronous active-high reset
//    load         latch tgt_duty / tgt_dir for every channel
//    tgt_duty     target duty, channel i at [i*CW +: CW]
//    tgt_dir      target direction per channel (0 fwd, 1 rev)
//    enable       per-channel run enable, low = immediate stop
//    pwm_out      registered PWM drive per channel
//    dir_out      registered direction drive per channel
//    busy         channel ramping, decelerating or in dead time
//    period_tick  high on the last cycle of each PWM period
// ============================================================================
module motor_pwm_multi #(
  parameter int CH        = 2,
  parameter int CW        = 16,
  parameter int RAMP_STEP = 1024,
  parameter int DEAD_PER  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CH*CW-1:0]  tgt_duty,
  input  logic [CH-1:0]     tgt_dir,
  input  logic [CH-1:0]     enable,
  output logic [CH-1:0]     pwm_out,
  output logic [CH-1:0]     dir_out,
  output logic [CH-1:0]     busy,
  output logic              period_tick
);

  localparam logic [CW-1:0] c_cnt_max   = '1;
  localparam logic [CW-1:0] c_step      = CW'(RAMP_STEP);
  localparam logic [7:0]    c_dead_last = 8'(DEAD_PER - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DECEL = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Shared period counter. The tick is decoded straight from the counter so
  // it lines up with the cycle in which cnt sits at its maximum.
  // --------------------------------------------------------------------------
  logic [CW-1:0] r_cnt;
  logic          w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_tick      = (r_cnt == c_cnt_max);
  assign period_tick = w_tick;

  // Move cur_v toward tgt_v by at most c_step without overshooting the target.
  // Computing the remaining distance first keeps every operation within CW
  // bits, so neither end of the range can wrap.
  function automatic logic [CW-1:0] f_ramp(input logic [CW-1:0] cur_v,
                                           input logic [CW-1:0] tgt_v);
    logic [CW-1:0] diff;
    if (tgt_v > cur_v) begin
      diff   = tgt_v - cur_v;
      f_ramp = (diff > c_step) ? (cur_v + c_step) : tgt_v;
    end else begin
      diff   = cur_v - tgt_v;
      f_ramp = (diff > c_step) ? (cur_v - c_step) : tgt_v;
    end
  endfunction

  // --------------------------------------------------------------------------
  // Per-channel controller
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CW-1:0] r_tduty, w_tduty_nxt;
    logic          r_tdir,  w_tdir_nxt;
    logic [CW-1:0] r_cur,   w_cur_nxt;
    state_t        r_state, w_state_nxt;
    logic [7:0]    r_dead,  w_dead_nxt;
    logic          r_dir,   w_dir_nxt;
    logic          r_pwm,   w_pwm_nxt;
    logic          r_busy,  w_busy_nxt;

    always_comb begin
      w_tduty_nxt = load ? tgt_duty[i*CW +: CW] : r_tduty;
      w_tdir_nxt  = load ? tgt_dir[i] : r_tdir;
      w_pwm_nxt   = enable[i] & (r_cnt < r_cur);
      w_cur_nxt   = r_cur;
      w_state_nxt = r_state;
      w_dead_nxt  = r_dead;
      w_dir_nxt   = r_dir;

      if (!enable[i]) begin
        // Stop at once; the direction line is left where it is.
        w_cur_nxt   = '0;
        w_state_nxt = ST_RUN;
        w_dead_nxt  = '0;
      end else if (w_tick) begin
        // Decisions use the target latched before this edge, so a load that
        // coincides with the tick only matters from the next period.
        if (r_state == ST_DEAD) begin
          if (r_dead == c_dead_last) begin
            // Dead time over: flip direction and take the first ramp step now,
            // so exactly DEAD_PER periods stay fully low.
            w_dead_nxt  = '0;
            w_dir_nxt   = r_tdir;
            w_state_nxt = ST_RUN;
            w_cur_nxt   = f_ramp('0, r_tduty);
          end else begin
            w_dead_nxt  = r_dead + 8'd1;
          end
        end else if (r_tdir == r_dir) begin
          // Also covers a DECEL whose reversal request was withdrawn.
          w_state_nxt = ST_RUN;
          w_cur_nxt   = f_ramp(r_cur, r_tduty);
        end else if (r_cur <= c_step) begin
          // Reaching zero (or already there) enters dead time on this tick.
          w_cur_nxt   = '0;
          w_state_nxt = ST_DEAD;
          w_dead_nxt  = '0;
        end else begin
          w_cur_nxt   = r_cur - c_step;
          w_state_nxt = ST_DECEL;
        end
      end

      w_busy_nxt = (w_state_nxt != ST_RUN) || (w_cur_nxt != w_tduty_nxt);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_tduty <= '0;
        r_tdir  <= 1'b0;
        r_cur   <= '0;
        r_state <= ST_RUN;
        r_dead  <= '0;
        r_dir   <= 1'b0;
        r_pwm   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_tduty <= w_tduty_nxt;
        r_tdir  <= w_tdir_nxt;
        r_cur   <= w_cur_nxt;
        r_state <= w_state_nxt;
        r_dead  <= w_dead_nxt;
        r_dir   <= w_dir_nxt;
        r_pwm   <= w_pwm_nxt;
        r_busy  <= w_busy_nxt;
      end
    end

    assign pwm_out[i] = r_pwm;
    assign dir_out[i] = r_dir;
    assign busy[i]    = r_busy;
  end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_pwm_multi
//  Description : Self-checking bench for motor_pwm_multi (CH=2, CW=8,
//                RAMP_STEP=64, DEAD_PER=2). A behavioural model predicts the
//                outputs each cycle into a scoreboard queue; per-period high
//                counts are also compared against fixed duty sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_pwm_multi;

  localparam int CH   = 2;
  localparam int CW   = 8;
  localparam int STEP = 64;
  localparam int DEAD = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           load;
  logic [CH*CW-1:0] tgt_duty;
  logic [CH-1:0]  tgt_dir;
  logic [CH-1:0]  enable;
  logic [CH-1:0]  pwm_out;
  logic [CH-1:0]  dir_out;
  logic [CH-1:0]  busy;
  logic           period_tick;

  motor_pwm_multi #(
    .CH        (CH),
    .CW        (CW),
    .RAMP_STEP (STEP),
    .DEAD_PER  (DEAD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .tgt_duty    (tgt_duty),
    .tgt_dir     (tgt_dir),
    .enable      (enable),
    .pwm_out     (pwm_out),
    .dir_out     (dir_out),
    .busy        (busy),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] exp_q[$];

  // Behavioural model state (0 = RUN, 1 = DECEL, 2 = DEAD)
  int m_cnt;
  int m_cur[CH];
  int m_tduty[CH];
  bit m_tdir[CH];
  int m_st[CH];
  int m_dc[CH];
  bit m_dir[CH];
  bit m_pwm[CH];
  bit m_busy[CH];

  int hi_acc[CH];
  int hi0, hi1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    end
  endtask

  function automatic int toward(input int c, input int t);
    if (t > c) return (t - c > STEP) ? c + STEP : t;
    return (c - t > STEP) ? c - STEP : t;
  endfunction

  // Predicts the state after the coming rising edge from the inputs now applied.
  task automatic model_step();
    bit tick;
    tick = (m_cnt == (1 << CW) - 1);
    if (rst) begin
      m_cnt = 0;
      for (int c = 0; c < CH; c++) begin
        m_cur[c] = 0; m_tduty[c] = 0; m_tdir[c] = 0; m_st[c] = 0;
        m_dc[c] = 0;  m_dir[c] = 0;   m_pwm[c] = 0;  m_busy[c] = 0;
      end
      return;
    end
    for (int c = 0; c < CH; c++) begin
      m_pwm[c] = enable[c] && (m_cnt < m_cur[c]);
      if (!enable[c]) begin
        m_cur[c] = 0; m_st[c] = 0; m_dc[c] = 0;
      end else if (tick) begin
        if (m_st[c] == 2) begin
          if (m_dc[c] == DEAD - 1) begin
            m_dc[c] = 0; m_dir[c] = m_tdir[c]; m_st[c] = 0;
            m_cur[c] = toward(0, m_tduty[c]);
          end else begin
            m_dc[c]++;
          end
        end else if (m_tdir[c] == m_dir[c]) begin
          m_st[c] = 0;
          m_cur[c] = toward(m_cur[c], m_tduty[c]);
        end else if (m_cur[c] <= STEP) begin
          m_cur[c] = 0; m_st[c] = 2; m_dc[c] = 0;
        end else begin
          m_cur[c] -= STEP; m_st[c] = 1;
        end
      end
      if (load) begin
        m_tduty[c] = int'(tgt_duty[c*CW +: CW]);
        m_tdir[c]  = tgt_dir[c];
      end
      m_busy[c] = (m_st[c] != 0) || (m_cur[c] != m_tduty[c]);
    end
    m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  // One clock: predict, push, clock, pop and compare, accumulate duty counts.
  task automatic step();
    logic [6:0] e;
    logic [6:0] o;
    model_step();
    exp_q.push_back({(m_cnt == (1 << CW) - 1), m_busy[1], m_busy[0],
                     m_dir[1], m_dir[0], m_pwm[1], m_pwm[0]});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {period_tick, busy, dir_out, pwm_out};
    chk("outs", 32'(o), 32'(e));
    if (rst) begin
      hi_acc[0] = 0; hi_acc[1] = 0;
    end else begin
      hi_acc[0] += int'(pwm_out[0]);
      hi_acc[1] += int'(pwm_out[1]);
      if (m_cnt == 0) begin
        hi0 = hi_acc[0]; hi1 = hi_acc[1];
        hi_acc[0] = 0;   hi_acc[1] = 0;
      end
    end
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Runs to the end of the current PWM period; optionally pulses load on the
  // tick cycle itself.
  task automatic run_period(input bit load_last = 1'b0);
    for (int k = 0; k < 256; k++) begin
      if (load_last && m_cnt == (1 << CW) - 1) load = 1'b1;
      step();
      if (m_cnt == 0) break;
    end
  endtask

  task automatic chk_period(input string tag, input int want0);
    run_period();
    chk(tag, 32'(hi0), 32'(want0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load = 1'b0; tgt_duty = '0; tgt_dir = '0; enable = '0;
    @(negedge clk);
    run_steps(3);
    chk("reset_outs", 32'({period_tick, busy, dir_out, pwm_out}), 32'd0);

    // Ramp up: ch0 -> 200, ch1 -> 100
    rst = 1'b0; enable = 2'b11; tgt_dir = 2'b00;
    tgt_duty = {8'd100, 8'd200}; load = 1'b1;
    chk_period("ramp_w0", 0);
    chk_period("ramp_w1", 64);
    chk("ch1_w1", 32'(hi1), 32'd64);
    chk_period("ramp_w2", 128);
    chk("busy0_ramping", 32'(busy[0]), 32'd1);
    chk("ch1_w2", 32'(hi1), 32'd100);
    chk_period("ramp_w3", 192);
    chk("busy0_done", 32'(busy[0]), 32'd0);
    chk_period("ramp_w4", 200);
    chk_period("ramp_w5", 200);

    // Reversal withdrawn during DECEL at 72
    tgt_dir = 2'b01; load = 1'b1;
    chk_period("abort_w6", 200);
    chk_period("abort_w7", 136);
    run_steps(10);
    tgt_dir = 2'b00; load = 1'b1;
    chk_period("abort_w8", 72);
    chk_period("abort_w9", 136);
    chk_period("abort_w10", 200);
    chk("abort_dir0", 32'(dir_out[0]), 32'd0);

    // Full reversal with dead time
    tgt_dir = 2'b01; load = 1'b1;
    chk_period("rev_w11", 200);
    chk_period("rev_w12", 136);
    chk_period("rev_w13", 72);
    chk_period("rev_w14", 8);
    chk_period("rev_dead1", 0);
    chk("rev_dir_held", 32'(dir_out[0]), 32'd0);
    chk_period("rev_dead2", 0);
    chk("rev_dir_flip", 32'(dir_out[0]), 32'd1);
    chk_period("rev_w17", 64);
    chk_period("rev_w18", 128);
    chk_period("rev_w19", 192);
    chk_period("rev_w20", 200);

    // Enable dropped mid-period on ch0
    run_steps(50);
    enable = 2'b10;
    step();
    chk("en_pwm0_off", 32'(pwm_out[0]), 32'd0);
    run_period();
    chk("en_ch1_w21", 32'(hi1), 32'd100);
    chk_period("en_w22", 0);
    chk("en_ch1_w22", 32'(hi1), 32'd100);
    enable = 2'b11;
    chk_period("en_w23", 0);
    chk_period("en_w24", 64);

    // Duty 0 boundary
    tgt_duty = {8'd100, 8'd0}; load = 1'b1;
    chk_period("d0_w25", 128);
    chk_period("d0_w26", 64);
    chk_period("d0_w27", 0);
    chk_period("d0_w28", 0);

    // Duty 255 boundary
    tgt_duty = {8'd255, 8'd255}; load = 1'b1;
    chk_period("dmax_w29", 0);
    chk_period("dmax_w30", 64);
    chk_period("dmax_w31", 128);
    chk_period("dmax_w32", 192);
    chk_period("dmax_w33", 255);
    chk("dmax_ch1_w33", 32'(hi1), 32'd255);

    // Load coincident with period_tick takes effect one period later
    tgt_duty = {8'd255, 8'd100};
    run_period(1'b1);
    chk("coinc_w34", 32'(hi0), 32'd255);
    chk_period("coinc_w35", 255);
    chk_period("coinc_w36", 191);
    chk_period("coinc_w37", 127);
    chk_period("coinc_w38", 100);

    // Reset asserted during DEAD
    tgt_dir = 2'b00; load = 1'b1;
    chk_period("rst_w39", 100);
    chk_period("rst_w40", 36);
    run_steps(30);
    chk("rst_pre_dir0", 32'(dir_out[0]), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_in_dead", 32'({period_tick, busy, dir_out, pwm_out}), 32'd0);
    run_steps(2);
    rst = 1'b0;
    chk_period("rst_after", 0);
    chk("rst_after_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
